// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 640x480 text-mode raster, 80x30 cells, 4-cycle pixel pipeline. Rev 1.0
// Optional blinking cursor is built when VGA_TEXT_CURSOR_EN is defined.
`default_nettype none

module vga_text_renderer #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int BLINK_FRAMES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [11:0] text_addr,
  input  logic [15:0] text_data,
  output logic [7:0]  font_ascii,
  output logic [3:0]  font_row,
  output logic [2:0]  font_col,
  input  logic        font_pixel,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [3:0]  color
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        w_visible, w_hs, w_vs, w_frame_end;
  logic [11:0] w_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= 10'd0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= 10'd0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  assign w_visible   = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs        = !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
  assign w_vs        = !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
  assign w_frame_end = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

  // row*80 = row*64 + row*16
  assign w_addr = {r_v_cnt[9:4], 6'b0} + {2'b0, r_v_cnt[9:4], 4'b0} + {5'b0, r_h_cnt[9:3]};

  // Stage 1: buffer address plus piped glyph coordinates and raw syncs
  logic [2:0] r1_col;
  logic [3:0] r1_row;
  logic       r1_vis, r1_hs, r1_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text_addr <= 12'd0;
      r1_col    <= 3'd0;
      r1_row    <= 4'd0;
      r1_vis    <= 1'b0;
      r1_hs     <= 1'b1;
      r1_vs     <= 1'b1;
    end else begin
      if (w_visible) text_addr <= w_addr;
      r1_col <= r_h_cnt[2:0];
      r1_row <= r_v_cnt[3:0];
      r1_vis <= w_visible;
      r1_hs  <= w_hs;
      r1_vs  <= w_vs;
    end
  end

  logic w_hit;

`ifdef VGA_TEXT_CURSOR_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [6:0]    r1_cell_x;
  logic [5:0]    r1_cell_y;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_cell_x <= 7'd0;
      r1_cell_y <= 6'd0;
    end else begin
      r1_cell_x <= r_h_cnt[9:3];
      r1_cell_y <= r_v_cnt[9:4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (w_frame_end) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_on  <= ~r_blink_on;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Underline-style cursor on the bottom two glyph scanlines of the addressed cell
  assign w_hit = (r1_cell_x == cursor_x) && (r1_cell_y == {1'b0, cursor_y}) &&
                 (cursor_x <= 7'd79) && (cursor_y <= 5'd29) &&
                 (r1_row >= 4'd14) && r_blink_on;
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_x, cursor_y, w_frame_end};
  assign w_hit = 1'b0;
`endif

  // Stage 2: glyph lookup address, cell attributes, cursor decision
  logic [3:0] r2_fg, r2_bg;
  logic       r2_hit, r2_vis, r2_hs, r2_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      font_ascii <= 8'd0;
      font_row   <= 4'd0;
      font_col   <= 3'd0;
      r2_fg      <= 4'd0;
      r2_bg      <= 4'd0;
      r2_hit     <= 1'b0;
      r2_vis     <= 1'b0;
      r2_hs      <= 1'b1;
      r2_vs      <= 1'b1;
    end else begin
      font_ascii <= text_data[7:0];
      font_row   <= r1_row;
      font_col   <= r1_col;
      r2_fg      <= text_data[11:8];
      r2_bg      <= text_data[15:12];
      r2_hit     <= w_hit;
      r2_vis     <= r1_vis;
      r2_hs      <= r1_hs;
      r2_vs      <= r1_vs;
    end
  end

  // Stage 3: covers the font ROM read latency
  logic [3:0] r3_fg, r3_bg;
  logic       r3_hit, r3_vis, r3_hs, r3_vs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_fg  <= 4'd0;
      r3_bg  <= 4'd0;
      r3_hit <= 1'b0;
      r3_vis <= 1'b0;
      r3_hs  <= 1'b1;
      r3_vs  <= 1'b1;
    end else begin
      r3_fg  <= r2_fg;
      r3_bg  <= r2_bg;
      r3_hit <= r2_hit;
      r3_vis <= r2_vis;
      r3_hs  <= r2_hs;
      r3_vs  <= r2_vs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color  <= 4'd0;
      active <= 1'b0;
      hsync  <= 1'b1;
      vsync  <= 1'b1;
    end else begin
      color  <= r3_vis ? ((font_pixel ^ r3_hit) ? r3_fg : r3_bg) : 4'd0;
      active <= r3_vis;
      hsync  <= r3_hs;
      vsync  <= r3_vs;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed checks of timing, addressing, colouring, cursor and reset
// on a reduced 80x70 raster (64x64 visible) so whole frames stay short.
`default_nettype none

module tb_vga_text_renderer;

  localparam int HT = 80;
  localparam int FRAME = 80 * 70;
`ifdef VGA_TEXT_CURSOR_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] text_addr;
  logic [15:0] text_data;
  logic [7:0]  font_ascii;
  logic [3:0]  font_row;
  logic [2:0]  font_col;
  logic        font_pixel;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        hsync, vsync, active;
  logic [3:0]  color;

  logic [15:0] tmem [0:4095];

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  int act_cnt, hs_low, vs_low;
  int hf[$];
  int vf[$];
  logic ph, pv;

  vga_text_renderer #(
    .H_VISIBLE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_VISIBLE(64), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .text_addr(text_addr), .text_data(text_data),
    .font_ascii(font_ascii), .font_row(font_row), .font_col(font_col),
    .font_pixel(font_pixel),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .hsync(hsync), .vsync(vsync), .active(active), .color(color)
  );

  always #5 clk = ~clk;

  // Character buffer: word for the presented address, captured by the DUT on the next edge
  assign text_data = tmem[text_addr];

  // Font ROM: glyph 'A' has its left four pixel columns lit on every scanline
  always @(posedge clk) font_pixel <= (font_ascii == 8'h41) && (font_col < 3'd4);

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_to(input int target);
    bit moved = 1'b0;
    while (ncyc < target) begin
      @(posedge clk);
      ncyc++;
      moved = 1'b1;
    end
    if (moved) #1;
  endtask

  // Output for counter index idx appears 4 cycles later
  task automatic at_pix(input int frame, input int h, input int v);
    run_to(frame * FRAME + v * HT + h + 4);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tmem[i] = 16'h0000;
    tmem[0]   = 16'h1F41;
    tmem[245] = 16'h2B41;
    cursor_x = 7'd5;
    cursor_y = 5'd3;
    rst_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_text_addr", text_addr, 12'd0);
    check_val("rst_font_ascii", font_ascii, 8'd0);
    check_val("rst_font_row", font_row, 4'd0);
    check_val("rst_font_col", font_col, 3'd0);
    check_val("rst_color", color, 4'd0);
    check_val("rst_active", active, 1'b0);
    check_val("rst_hsync", hsync, 1'b1);
    check_val("rst_vsync", vsync, 1'b1);

    @(negedge clk);
    rst_n = 1'b1;
    ncyc = 0;

    run_to(3);
    check_val("first_active_pre", active, 1'b0);
    run_to(4);
    check_val("first_active", active, 1'b1);
    check_val("pix00_lit", color, 4'hF);
    run_to(5);
    check_val("font_ascii_h3", font_ascii, 8'h41);
    check_val("font_row_h3", font_row, 4'd0);
    check_val("font_col_h3", font_col, 3'd3);
    check_val("pix10_lit", color, 4'hF);
    at_pix(0, 4, 0);
    check_val("pix40_unlit", color, 4'h1);

    run_to(35 * HT + 17 + 1);
    check_val("addr_17_35", text_addr, 12'd162);
    run_to(35 * HT + 64 + 1);
    check_val("addr_hold_blank", text_addr, 12'd167);

    at_pix(0, 40, 61);
    check_val("cur_f0_row13", color, 4'hB);
    at_pix(0, 40, 62);
    check_val("cur_f0_lit", color, CUR_EN ? 4'h2 : 4'hB);
    at_pix(0, 44, 62);
    check_val("cur_f0_unlit", color, CUR_EN ? 4'hB : 4'h2);

    // Frames 1 and 2 sampled at output alignment
    act_cnt = 0; hs_low = 0; vs_low = 0; ph = 1'b1; pv = 1'b1;
    run_to(FRAME + 4);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (active) act_cnt++;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (ph && !hsync) hf.push_back(i);
      if (pv && !vsync) vf.push_back(i);
      ph = hsync;
      pv = vsync;
      run_to(ncyc + 1);
    end
    check_val("active_count", act_cnt, 32'd8192);
    check_val("hsync_low", hs_low, 32'd1120);
    check_val("vsync_low", vs_low, 32'd320);
    check_val("hsync_edges", hf.size(), 32'd140);
    check_val("vsync_edges", vf.size(), 32'd2);
    check_val("hsync_first", (hf.size() > 0) ? hf[0] : -1, 32'd68);
    check_val("hsync_period", (hf.size() > 1) ? hf[1] - hf[0] : -1, 32'd80);
    check_val("vsync_first", (vf.size() > 0) ? vf[0] : -1, 32'd5280);
    check_val("vsync_period", (vf.size() > 1) ? vf[1] - vf[0] : -1, 32'd5600);

    at_pix(3, 40, 62);
    check_val("cur_f3_lit", color, 4'hB);
    at_pix(3, 44, 62);
    check_val("cur_f3_unlit", color, 4'h2);
    at_pix(4, 40, 62);
    check_val("cur_f4_lit", color, CUR_EN ? 4'h2 : 4'hB);

    run_to(5 * FRAME + 40 * HT + 30);
    check_val("pre_rst_active", active, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("async_active", active, 1'b0);
    check_val("async_color", color, 4'd0);
    check_val("async_hsync", hsync, 1'b1);
    check_val("async_vsync", vsync, 1'b1);
    check_val("async_text_addr", text_addr, 12'd0);
    check_val("async_font_row", font_row, 4'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ncyc = 0;
    run_to(3);
    check_val("rerun_active_pre", active, 1'b0);
    run_to(4);
    check_val("rerun_active", active, 1'b1);
    check_val("rerun_pix00", color, 4'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
